// File: rtl/uart_transmitter_if.sv
`default_nettype none
// =====================================================================
// Module   : uart_transmitter_if
// Purpose  : Byte handshake between a parallel source and uart_transmitter.
// Revision : 1.0
// =====================================================================
interface uart_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// =====================================================================
// Module   : uart_transmitter
// Purpose  : FIFO-buffered UART transmitter, 8N1, MSB first.
//            Optional even parity bit enabled by macro UART_TX_PARITY_EN.
// Revision : 1.0
// =====================================================================
module uart_transmitter #(
    parameter int BAUD_DIV = 20,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    uart_transmitter_if.slave     tx_if,
    output logic                  uart_tx,
    output logic                  tx_busy,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]    c_DEPTH     = CNT_W'(DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic [7:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [2:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;

    logic w_push;
    logic w_pop;
    logic w_baud_wrap;
    logic w_fifo_empty;
    logic w_line;

    assign tx_if.tx_ready = (r_count < c_DEPTH);
    assign w_push         = tx_if.tx_valid && tx_if.tx_ready;
    assign w_fifo_empty   = (r_count == '0);
    assign w_baud_wrap    = (r_baud_cnt == c_BAUD_LAST);
    // A byte leaves the FIFO when the shifter is (re)loaded: from IDLE, or
    // at the end of a stop bit so consecutive frames have no idle gap.
    assign w_pop          = !w_fifo_empty &&
                            ((r_state == c_IDLE) || ((r_state == c_STOP) && w_baud_wrap));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_START:  w_line = 1'b0;
            c_DATA:   w_line = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            c_PARITY: w_line = ^r_shift;
`endif
            default:  w_line = 1'b1;
        endcase
    end

    // Line output is registered from the current state, so every bit appears
    // one cycle after its state is entered and still lasts BAUD_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_line;
            if ((r_state == c_IDLE) || w_baud_wrap) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            end
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_baud_wrap) begin
                        r_bit_idx <= 3'd7;
                        r_state   <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_baud_wrap) begin
                        if (r_bit_idx == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= c_PARITY;
`else
                            r_state <= c_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_PARITY: begin
                    if (w_baud_wrap) begin
                        r_state <= c_STOP;
                    end
                end
`endif
                c_STOP: begin
                    if (w_baud_wrap) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= c_START;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign uart_tx    = r_tx;
    assign fifo_count = r_count;
    assign tx_busy    = (r_state != c_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// =====================================================================
// Module   : tb_uart_transmitter
// Purpose  : Scoreboard bench for uart_transmitter (directed + random bytes).
// Revision : 1.0
// =====================================================================
module tb_uart_transmitter;

    localparam int BD    = 20;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * BD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_transmitter_if bus ();
    uart_transmitter_if bus2 ();

    logic             uart_tx, tx_busy, uart_tx2, tx_busy2;
    logic [CNT_W-1:0] fifo_count, fifo_count2;

    uart_transmitter #(.BAUD_DIV(BD), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .tx_if(bus),
        .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    uart_transmitter #(.BAUD_DIV(2), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst(rst), .tx_if(bus2),
        .uart_tx(uart_tx2), .tx_busy(tx_busy2), .fifo_count(fifo_count2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each accepted byte has a push edge a and pop edge p.
    typedef struct {
        logic [7:0] d;
        int         a;
        int         p;
    } rec_t;

    rec_t recs[$];
    rec_t exp_q[$];
    int   r_edge   = -1;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic bit alive(rec_t r, int x);
        return !(r_edge >= 0 && x >= r_edge && r.a < r_edge);
    endfunction

    function automatic int occ_after(int x);
        int n = 0;
        foreach (recs[i])
            if (alive(recs[i], x) && recs[i].a <= x && recs[i].p > x) n++;
        return n;
    endfunction

    function automatic bit sending(int x);
        foreach (recs[i])
            if (alive(recs[i], x) && recs[i].p <= x && x < recs[i].p + F) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic frame_lvl(logic [7:0] d, int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[8-b];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- driver (runs at posedge + 1) ----------------
    bit acc;

    task automatic drive(input bit v, input logic [7:0] d, output bit accepted);
        int   e = cyc + 1;
        int   pp;
        rec_t r;
        bus.tx_valid = v;
        bus.tx_data  = d;
        accepted = v && !rst && (occ_after(cyc) < DEPTH);
        if (accepted) begin
            pp = e + 1;
            if (recs.size() > 0 && alive(recs[recs.size()-1], e) &&
                recs[recs.size()-1].p + F > pp)
                pp = recs[recs.size()-1].p + F;
            r.d = d; r.a = e; r.p = pp;
            recs.push_back(r);
            exp_q.push_back(r);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_n(input int n);
        bit a;
        repeat (n) drive(1'b0, 8'h00, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tx_valid  = 1'b0;
        bus2.tx_valid = 1'b0;
        r_edge = cyc + 1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int last = 0;
        bit a;
        foreach (recs[i])
            if (alive(recs[i], cyc) && recs[i].p + F + 1 > last) last = recs[i].p + F + 1;
        for (int k = 0; k < 5000 && cyc <= last + 1; k++) drive(1'b0, 8'h00, a);
        chk("scoreboard_drained", exp_q.size() + int'(mon_active), 0);
        recs.delete();
        exp_q.delete();
        r_edge = -1;
    endtask

    // ---------------- monitor (runs at negedge) ----------------
    bit         mon_en = 1'b0;
    bit         mon_active = 1'b0;
    bit         mon_bad;
    int         mon_s;
    rec_t       mon_rec;
    logic [7:0] mon_rx;
    int         mx, midx, mb, mocc;

    always @(negedge clk) begin
        if (mon_en) begin
            mx = cyc;
            if (r_edge >= 0 && mx >= r_edge) begin
                while (exp_q.size() > 0 && exp_q[0].a < r_edge) void'(exp_q.pop_front());
                if (mon_active && mon_rec.a < r_edge) mon_active = 1'b0;
            end
            mocc = occ_after(mx);
            chk("fifo_count", int'(fifo_count), mocc);
            chk("tx_ready", int'(bus.tx_ready), int'(mocc < DEPTH));
            chk("tx_busy", int'(tx_busy), int'(mocc > 0 || sending(mx)));
            if (mon_active) begin
                midx = mx - mon_s;
                mb   = midx / BD;
                if (uart_tx !== frame_lvl(mon_rec.d, mb)) mon_bad = 1'b1;
                if (mb >= 1 && mb <= 8 && (midx % BD) == BD / 2) mon_rx[8-mb] = uart_tx;
                if (midx == F - 1) begin
                    mon_active = 1'b0;
                    n_checks++;
                    if (mon_bad) begin
                        n_errors++;
                        $display("FAIL frame: received %02h, expected %02h (line level off inside frame)",
                                 mon_rx, mon_rec.d);
                    end
                end
            end else if (uart_tx !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_start: actual line %b at cycle %0d, expected idle 1", uart_tx, mx);
                end else begin
                    mon_rec = exp_q.pop_front();
                    chk("frame_start_cycle", mx, mon_rec.p + 1);
                    mon_active = 1'b1;
                    mon_s      = mx;
                    mon_bad    = 1'b0;
                    mon_rx     = 8'h00;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         target, n2, rel;
        bit         have, v;
        logic [7:0] pend;

        bus.tx_valid  = 1'b0; bus.tx_data  = 8'h00;
        bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uart_tx", int'(uart_tx), 1);
        chk("reset_tx_ready", int'(bus.tx_ready), 1);
        chk("reset_tx_busy", int'(tx_busy), 0);
        chk("reset_fifo_count", int'(fifo_count), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle_n(2);

        // single byte
        drive(1'b1, 8'hA5, acc);
        wait_idle();

        // back-to-back
        drive(1'b1, 8'h00, acc);
        drive(1'b1, 8'hFF, acc);
        drive(1'b1, 8'h3C, acc);
        wait_idle();

        // FIFO full with a held valid
        for (int i = 1; i <= 7; i++) drive(1'b1, 8'(i), acc);
        drive(1'b0, 8'h00, acc);
        wait_idle();

        // reset during the 4th data bit of the first frame
        drive(1'b1, 8'h55, acc);
        drive(1'b1, 8'hAA, acc);
        target = recs[0].p + 1 + 4 * BD + 5;
        for (int k = 0; k < 1000 && cyc + 1 < target; k++) drive(1'b0, 8'h00, acc);
        do_reset();
        idle_n(2 * F);
        wait_idle();

        // parity patterns
        drive(1'b1, 8'h07, acc);
        drive(1'b1, 8'h03, acc);
        wait_idle();

        // random traffic: sparse phase, then a dense phase that saturates the FIFO
        have = 1'b0;
        pend = 8'h00;
        for (int i = 0; i < 1400; i++) begin
            if (have) v = 1'b1;
            else begin
                v    = ($urandom_range(0, 99) < ((i < 800) ? 3 : 40));
                pend = 8'($urandom);
            end
            drive(v, pend, acc);
            have = v && !acc;
        end
        drive(1'b0, 8'h00, acc);
        wait_idle();

        // divider edge case on the BAUD_DIV=2 instance
        chk("div2_tx_ready", int'(bus2.tx_ready), 1);
        bus2.tx_data  = 8'h81;
        bus2.tx_valid = 1'b1;
        n2 = cyc + 1;
        @(posedge clk); #1;
        bus2.tx_valid = 1'b0;
        for (int k = 0; k < 2 * NB + 4; k++) begin
            @(negedge clk);
            rel = cyc - (n2 + 2);
            chk("div2_line", int'(uart_tx2),
                int'((rel < 0 || rel >= 2 * NB) ? 1'b1 : frame_lvl(8'h81, rel / 2)));
        end
        chk("div2_busy_end", int'(tx_busy2), 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
